// File: rtl/keypad_scan_ctrl_if.sv
// Key handoff bundle between the keypad scanner (master) and the input controller (slave).
interface keypad_scan_ctrl_if;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_read;

    modport master (output key_code, output key_valid, input key_read);
    modport slave  (input key_code, input key_valid, output key_read);
endinterface

// File: rtl/keypad_scan_ctrl.sv
// 4x4 active-low keypad scanner with press/release debounce and a valid/read key handoff.
// Optional MULTI_KEY_REJECT_EN: chorded or ghosted row patterns are never reported.
module keypad_scan_ctrl #(
    parameter int SCAN_DIV        = 4,
    parameter int DEBOUNCE_CYCLES = 8
) (
    input  logic               clk,
    input  logic               RST,
    input  logic [3:0]         RowIn,
    output logic [3:0]         ColOut,
    output logic [2:0]         scan_state,
    keypad_scan_ctrl_if.master kif
);

    typedef enum logic [2:0] {
        SCAN     = 3'd0,
        DEBOUNCE = 3'd1,
        PRESSED  = 3'd3,
        WAIT_REL = 3'd4,
        REL_DB   = 3'd5
    } state_e;

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DB_LAST    = CW'(DEBOUNCE_CYCLES - 1);

    state_e        state_q;
    logic [1:0]    col_q;
    logic [1:0]    row_q;
    logic [DW-1:0] dwell_q;
    logic [CW-1:0] db_q;
    logic          valid_q;
    logic [3:0]    code_q;

    logic [1:0]    low_row;
    logic [2:0]    n_low;
    logic          idle_rows;
    logic          key_seen;
    logic          db_match;

    // Lowest-index low row wins; n_low counts how many rows are pulled low.
    always_comb begin
        low_row = '0;
        n_low   = '0;
        for (int unsigned i = 4; i > 0; i--) begin
            if (!RowIn[i-1]) low_row = 2'(i - 1);
        end
        for (int unsigned i = 0; i < 4; i++) begin
            n_low = n_low + 3'(!RowIn[i]);
        end
    end

    assign idle_rows = (RowIn == 4'hF);

`ifdef MULTI_KEY_REJECT_EN
    assign key_seen = (n_low == 3'd1);
    assign db_match = (RowIn == ~(4'b0001 << row_q));
`else
    assign key_seen = !idle_rows;
    assign db_match = !idle_rows && (low_row == row_q);
`endif

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state_q <= SCAN;
            col_q   <= '0;
            row_q   <= '0;
            dwell_q <= '0;
            db_q    <= '0;
            valid_q <= 1'b0;
            code_q  <= '0;
        end else begin
            case (state_q)
                SCAN: begin
                    if (dwell_q == DWELL_LAST) begin
                        dwell_q <= '0;
                        if (key_seen) begin
                            row_q   <= low_row;
                            db_q    <= '0;
                            state_q <= DEBOUNCE;
                        end else begin
                            col_q <= col_q + 2'd1;
                        end
                    end else begin
                        dwell_q <= dwell_q + DW'(1);
                    end
                end
                DEBOUNCE: begin
                    // Dwell was already cleared on entry, so a mismatch rescans the same column afresh.
                    if (db_match) begin
                        if (db_q == DB_LAST) begin
                            db_q    <= '0;
                            valid_q <= 1'b1;
                            code_q  <= {row_q, col_q};
                            state_q <= PRESSED;
                        end else begin
                            db_q <= db_q + CW'(1);
                        end
                    end else begin
                        db_q    <= '0;
                        state_q <= SCAN;
                    end
                end
                PRESSED: begin
                    if (kif.key_read) begin
                        valid_q <= 1'b0;
                        state_q <= WAIT_REL;
                    end
                end
                WAIT_REL: begin
                    if (idle_rows) begin
                        db_q    <= '0;
                        state_q <= REL_DB;
                    end
                end
                REL_DB: begin
                    if (idle_rows) begin
                        if (db_q == DB_LAST) begin
                            db_q    <= '0;
                            dwell_q <= '0;
                            col_q   <= col_q + 2'd1;
                            state_q <= SCAN;
                        end else begin
                            db_q <= db_q + CW'(1);
                        end
                    end else begin
                        db_q    <= '0;
                        state_q <= WAIT_REL;
                    end
                end
                default: state_q <= SCAN;
            endcase
        end
    end

    assign ColOut        = ~(4'b0001 << col_q);
    assign scan_state    = state_q;
    assign kif.key_valid = valid_q;
    assign kif.key_code  = code_q;

endmodule

// File: doc/keypad_scan_ctrl.md
Name: keypad_scan_ctrl

Overview:
Scans the 4x4 active-low keypad matrix by driving one column low at a time. It debounces presses and releases and hands each debounced key index (0-15) to the calculator's input controller. The handoff uses a valid/read handshake. It sits between the board pins (ColOut/RowIn) and the input control FSM, and is the only block that owns the keypad matrix.

Parameters:
SCAN_DIV, 4, clock cycles each column is held active (dwell); minimum 2
DEBOUNCE_CYCLES, 8, consecutive stable cycles needed to accept a press or release; minimum 1

Ports:
clk  input  1  system clock
RST  input  1  reset, asynchronous, active-high
RowIn  input  4  keypad rows, active-low (bit r low = key in row r pressed on active column)
ColOut  output  4  column drive, active-low one-cold (~(4'b0001 << col))
key_code  output  4  debounced key index = row*4 + col; valid only while key_valid=1
key_valid  output  1  debounced key available; held until key_read
key_read  input  1  consumer acknowledge; sampled only while key_valid=1
scan_state  output  3  current FSM state encoding (debug/bench visibility)

Behaviour:
- Reset (async, RST=1):
  - state=SCAN, col=0, ColOut=4'b1110, dwell and debounce counters=0.
  - key_valid=0, key_code=0.
  - Takes effect immediately, including mid-debounce or mid-handshake; any pending key is dropped.
- State encodings: SCAN=0, DEBOUNCE=1, PRESSED=3, WAIT_REL=4, REL_DB=5.
- SCAN:
  - The dwell counter counts 0..SCAN_DIV-1. RowIn is sampled only in the last dwell cycle, which gives the settling time.
  - If the sample is 4'b1111: col advances (3 wraps to 0) and dwell restarts.
  - If any row is low: latch col and the lowest-index low row (priority row0 > row3), freeze ColOut, and go to DEBOUNCE.
- DEBOUNCE:
  - ColOut stays frozen. Each cycle RowIn is compared with the latched one-cold row pattern.
  - Match: increment the counter. On reaching DEBOUNCE_CYCLES, go to PRESSED with key_code = row*4+col.
  - Mismatch: clear the counter and return to SCAN on the same column with dwell restarted. No key is emitted.
- PRESSED:
  - key_valid=1 and key_code stays stable.
  - key_valid rises exactly DEBOUNCE_CYCLES+1 cycles after the sampling cycle in SCAN.
  - key_read=1 in a cycle: key_valid=0 the next cycle, go to WAIT_REL.
  - A key released before key_read does not withdraw key_valid; the press event is committed.
- WAIT_REL:
  - ColOut stays frozen.
  - RowIn==4'b1111: go to REL_DB with counter=0.
- REL_DB:
  - Needs DEBOUNCE_CYCLES consecutive cycles of RowIn==4'b1111. Then go to SCAN at col+1 (wrapping) with dwell restarted.
  - Any low row clears the counter and returns to WAIT_REL.
  - Each physical press yields exactly one key_valid pulse-train; there is no auto-repeat.
- Simultaneous keys in the same column: the lowest row wins. Keys in other columns are invisible while ColOut is frozen.
- key_read asserted while key_valid=0: ignored.

Optional Feature:
MULTI_KEY_REJECT_EN
- Defined:
  - A SCAN sample with more than one low row is treated as no key; col advances.
  - In DEBOUNCE, any cycle where RowIn is not exactly the latched one-cold pattern counts as a mismatch.
  - Ghosted or chorded presses are never reported.
- Undefined: lowest-row priority as above.

Test Plan:
- Reset values: assert RST mid-simulation -> ColOut=4'b1110, key_valid=0, key_code=0, scan_state=0 asynchronously, with no clock edge required.
- Single press: drive RowIn=4'b1110 while ColOut=4'b1011 (key 2) -> key_valid=1 with key_code=2, DEBOUNCE_CYCLES+1 cycles after the sample. Pulse key_read -> key_valid=0 next cycle. Release -> scan resumes at ColOut=4'b0111.
- Keys 15 then 12: RowIn=4'b0111 on col 3 -> key_code=15; after the handshake and release, RowIn=4'b0111 on col 0 -> key_code=12.
- Bounce: toggle RowIn low/high every 3 cycles for 40 cycles (DEBOUNCE_CYCLES=8) -> no key_valid. Then hold low for 8 cycles -> exactly one key_valid.
- Held key and late read: hold key 5 for 200 cycles and delay key_read 50 cycles -> key_valid held with code 5 throughout, exactly one event. Release bounce of 2 low blips -> no second event.
- Two rows low on col 1 (RowIn=4'b1100):
  - Without the macro -> key_code=1.
  - With MULTI_KEY_REJECT_EN -> no key_valid, and scanning continues to col 2.
